// File: rtl/sevenseg_scan_driver.sv
// Time-multiplexed scan driver for a common-anode 7-segment display.
// One digit snapshot per frame, optional leading-zero blanking, anode guard band per slot.
module sevenseg_scan_driver #(
  parameter int unsigned DIGITS      = 5,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned GUARD       = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        ones,
  input  logic [3:0]        tens,
  input  logic [3:0]        hundreds,
  input  logic [3:0]        thousands,
  input  logic [3:0]        tenThousands,
  input  logic              blankZeros,
  output logic [6:0]        segments,
  output logic [DIGITS-1:0] anodes,
  output logic              frameStrobe
);

  localparam int unsigned TW = $clog2(REFRESH_DIV);
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SW = DIGITS * 4;
  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [TW-1:0] TICK_GUARD = TW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state, state_nx;
  logic [IW-1:0]           idx;
  logic [TW-1:0]           tick;
  logic [DIGITS-1:0][3:0]  shadow;
  logic [DIGITS-1:0][3:0]  din_snap;
  logic                    shadow_blank;
  logic                    slot_end;
  logic                    load;
  logic [DIGITS-1:0]       blank;
  logic                    zero_above;
  logic [6:0]              seg_nx;
  logic [DIGITS-1:0]       an_nx;
  logic                    strobe_nx;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Digit ports are fixed at five; fewer DIGITS truncates, more zero-fills the top.
  assign din_snap = SW'({tenThousands, thousands, hundreds, tens, ones});
  assign slot_end = (tick == TICK_LAST);
  assign load     = (state == IDLE) || (slot_end && (idx == IDX_LAST));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = SCAN;
      SCAN:    state_nx = SCAN;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx          <= '0;
      tick         <= '0;
      shadow       <= '0;
      shadow_blank <= 1'b0;
    end else begin
      if (state == IDLE) begin
        idx  <= '0;
        tick <= '0;
      end else if (slot_end) begin
        tick <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end
      if (load) begin
        shadow       <= din_snap;
        shadow_blank <= blankZeros;
      end
    end
  end

  // A digit is blanked only if it and every more-significant digit are zero.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int unsigned i = DIGITS - 1; i > 0; i--) begin
      zero_above = zero_above & (shadow[i] == 4'd0);
      blank[i]   = shadow_blank & zero_above;
    end
  end

  always_comb begin
    an_nx     = '1;
    seg_nx    = 7'h7F;
    strobe_nx = load;
    if (state == SCAN && !blank[idx]) begin
      seg_nx = decode(shadow[idx]);
      if (tick >= TICK_GUARD) an_nx[idx] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      anodes      <= '1;
      segments    <= 7'h7F;
      frameStrobe <= 1'b0;
    end else begin
      anodes      <= an_nx;
      segments    <= seg_nx;
      frameStrobe <= strobe_nx;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with DIGITS=5, REFRESH_DIV=8, GUARD=2.
module tb_sevenseg_scan_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ones, tens, hundreds, thousands, tenThousands;
  logic       blankZeros;
  logic [6:0] segments;
  logic [4:0] anodes;
  logic       frameStrobe;

  int errors = 0;
  int checks = 0;

  sevenseg_scan_driver #(
    .DIGITS      (5),
    .REFRESH_DIV (8),
    .GUARD       (2)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ones         (ones),
    .tens         (tens),
    .hundreds     (hundreds),
    .thousands    (thousands),
    .tenThousands (tenThousands),
    .blankZeros   (blankZeros),
    .segments     (segments),
    .anodes       (anodes),
    .frameStrobe  (frameStrobe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // digits packed {tenThousands, thousands, hundreds, tens, ones}
  task automatic set_digits(input logic [4:0][3:0] d, input logic b);
    {tenThousands, thousands, hundreds, tens, ones} = d;
    blankZeros = b;
  endtask

  // Walks one 40-cycle frame; the next frame's inputs are applied during slot 2.
  task automatic run_frame(input string name,
                           input logic [4:0][6:0] eseg,
                           input logic [4:0][4:0] ean,
                           input logic [4:0][3:0] nd,
                           input logic nb);
    for (int s = 0; s < 5; s++) begin
      for (int t = 0; t < 8; t++) begin
        step();
        if (s == 2 && t == 0) set_digits(nd, nb);
        check($sformatf("%s s%0d t%0d seg", name, s, t), 32'(segments), 32'(eseg[s]));
        check($sformatf("%s s%0d t%0d an", name, s, t), 32'(anodes),
              (t < 2) ? 32'h1F : 32'(ean[s]));
        check($sformatf("%s s%0d t%0d strobe", name, s, t), 32'(frameStrobe),
              (s == 4 && t == 7) ? 32'd1 : 32'd0);
      end
    end
  endtask

  localparam logic [4:0][4:0] AN_ALL = {5'b01111, 5'b10111, 5'b11011, 5'b11101, 5'b11110};

  task automatic reset_and_start();
    reset_n = 1'b0;
    step();
    check("rst an", 32'(anodes), 32'h1F);
    check("rst seg", 32'(segments), 32'h7F);
    check("rst strobe", 32'(frameStrobe), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("e0 strobe", 32'(frameStrobe), 32'd1);
    check("e0 an", 32'(anodes), 32'h1F);
    check("e0 seg", 32'(segments), 32'h7F);
  endtask

  initial begin
    reset_n = 1'b0;
    set_digits({4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 1'b0);
    step();
    reset_and_start();

    run_frame("f1", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, AN_ALL,
              {4'd1, 4'd2, 4'd3, 4'd4, 4'd7}, 1'b0);
    run_frame("f2", {7'h79, 7'h24, 7'h30, 7'h19, 7'h78}, AN_ALL,
              {4'd0, 4'd0, 4'd0, 4'd4, 4'd2}, 1'b1);
    run_frame("f3", {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24},
              {5'h1F, 5'h1F, 5'h1F, 5'b11101, 5'b11110},
              {4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1'b1);
    run_frame("f4", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
              {5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'b11110},
              {4'd0, 4'd0, 4'd0, 4'hF, 4'hA}, 1'b0);
    run_frame("f5", {7'h40, 7'h40, 7'h40, 7'h0E, 7'h08}, AN_ALL,
              {4'd0, 4'd1, 4'd0, 4'd0, 4'd0}, 1'b1);
    run_frame("f6", {7'h7F, 7'h79, 7'h40, 7'h40, 7'h40},
              {5'h1F, 5'b10111, 5'b11011, 5'b11101, 5'b11110},
              {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 1'b0);

    for (int i = 0; i < 13; i++) step();
    reset_and_start();
    run_frame("f7", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, AN_ALL,
              {4'd1, 4'd2, 4'd3, 4'd4, 4'd5}, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
